// File: rtl/generic_sram_line_en_target.sv
// rtl/generic_sram_line_en_target.sv - memory-end responder of the generic SRAM line-enable interface
// Word array with post-reset clear sweep, combinational read with hold, error flags and access counters.
module generic_sram_line_en_target #(
   parameter int                       NUM_ADDR_BITS = 32,
   parameter int                       NUM_DATA_BITS = 32,
   parameter int                       MEM_ADDR_BITS = 10,
   parameter logic [NUM_DATA_BITS-1:0] INIT_VALUE    = '0,
   parameter logic [31:0]              ERR_VALUE     = 32'hDEADBEEF,
   parameter int                       COUNT_BITS    = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_ADDR_BITS-1:0] addr,
   input  logic [NUM_DATA_BITS-1:0] write_data,
   input  logic                     write_en,
   input  logic                     read_en,
   output logic [NUM_DATA_BITS-1:0] read_data,
   output logic                     init_done,
   output logic [COUNT_BITS-1:0]    write_count,
   output logic [COUNT_BITS-1:0]    read_count,
   output logic                     proto_err,
   output logic                     range_err
);

   localparam logic [NUM_DATA_BITS-1:0] ERR_DATA = NUM_DATA_BITS'(ERR_VALUE);

   typedef enum logic {ST_CLEAR, ST_READY} state_e;

   state_e                     state_q, state_d;
   logic [MEM_ADDR_BITS-1:0]   sweep_idx_q, sweep_idx_d;
   logic                       init_done_q;
   logic                       sweep_we;
   logic [NUM_DATA_BITS-1:0]   hold_q;
   logic [COUNT_BITS-1:0]      write_count_q, read_count_q;
   logic                       proto_err_q, range_err_q;
   logic [NUM_DATA_BITS-1:0]   mem [2**MEM_ADDR_BITS];

   logic                       any_acc, in_range, ok, wr_ok, rd_ok;
   logic [MEM_ADDR_BITS-1:0]   addr_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         sweep_idx_q <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         init_done_q <= (state_d == ST_READY);
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_CLEAR && (&sweep_idx_q)) begin
         state_d = ST_READY;
      end
   end

   always_comb begin
      sweep_we    = (state_q == ST_CLEAR);
      sweep_idx_d = sweep_we ? sweep_idx_q + MEM_ADDR_BITS'(1) : sweep_idx_q;
   end

   assign any_acc  = read_en | write_en;
   assign in_range = (addr[NUM_ADDR_BITS-1:MEM_ADDR_BITS] == '0);
   assign ok       = init_done_q & in_range;
   assign wr_ok    = write_en & ok;
   assign rd_ok    = read_en & ~write_en & ok;
   assign addr_idx = addr[MEM_ADDR_BITS-1:0];

   // The sweep owns the write port while clearing; wr_ok cannot fire then since init_done_q is low.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (sweep_we) begin
            mem[sweep_idx_q] <= INIT_VALUE;
         end else if (wr_ok) begin
            mem[addr_idx] <= write_data;
         end
      end
   end

   assign read_data = read_en ? (rd_ok ? mem[addr_idx] : ERR_DATA) : hold_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_q        <= '0;
         write_count_q <= '0;
         read_count_q  <= '0;
         proto_err_q   <= 1'b0;
         range_err_q   <= 1'b0;
      end else begin
         if (read_en) begin
            hold_q <= read_data;
         end
         if (wr_ok && write_count_q != '1) begin
            write_count_q <= write_count_q + COUNT_BITS'(1);
         end
         if (rd_ok && read_count_q != '1) begin
            read_count_q <= read_count_q + COUNT_BITS'(1);
         end
         if ((read_en & write_en) | (any_acc & ~init_done_q)) begin
            proto_err_q <= 1'b1;
         end
         if (any_acc & init_done_q & ~in_range) begin
            range_err_q <= 1'b1;
         end
      end
   end

   assign init_done   = init_done_q;
   assign write_count = write_count_q;
   assign read_count  = read_count_q;
   assign proto_err   = proto_err_q;
   assign range_err   = range_err_q;

endmodule
